// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main controller for the 16-bit CPU: sequences fetch/decode/execute/memory/writeback,
// handles the memory ready handshake with a bounded wait, and traps or halts on request.
module multicycle_control_fsm #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       OPCODE,
    input  logic [1:0]       FUNCT,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd, StMemWr,
        StWbAlu, StWbMem, StBranch, StHalt, StTrap
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   count_q;
    logic               timeout;
    logic               retire;

    assign timeout = !MemReady && (wait_q == WaitLast);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StFetch;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:   if (MemReady) state_d = StDecode; else if (timeout) state_d = StTrap;
            StDecode: begin
                case (OPCODE)
                    4'b0000:                   state_d = (FUNCT == 2'b11) ? StTrap : StExecR;
                    4'b0001, 4'b0010:          state_d = FUNCT[1] ? StTrap : StExecR;
                    4'b0100, 4'b0101:          state_d = StMemAddr;
                    4'b0110, 4'b0111:          state_d = StBranch;
                    4'b1001, 4'b1010, 4'b1011: state_d = StExecI;
                    4'b1111:                   state_d = StHalt;
                    default:                   state_d = StTrap;
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StMemAddr: state_d = (OPCODE == 4'b0100) ? StMemRd : StMemWr;
            StMemRd:   if (MemReady) state_d = StWbMem; else if (timeout) state_d = StTrap;
            StMemWr:   if (MemReady) state_d = StFetch; else if (timeout) state_d = StTrap;
            StWbAlu, StWbMem, StBranch: state_d = StFetch;
            StHalt:    state_d = StHalt;
            StTrap:    state_d = StTrap;
            default:   state_d = StTrap;
        endcase
    end

    // The counter only survives while a wait state holds itself; any move (entry, ready) clears it.
    always_comb begin
        wait_d = '0;
        if ((state_d == state_q) &&
            (state_q == StFetch || state_q == StMemRd || state_q == StMemWr)) begin
            wait_d = wait_q + 8'd1;
        end
        retire = (state_d == StFetch) &&
                 (state_q == StWbAlu || state_q == StWbMem ||
                  state_q == StMemWr || state_q == StBranch);
    end

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        Halted    = 1'b0;
        IllegalOp = 1'b0;
        if (!Reset) begin
            unique case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                StDecode:  ALUSrcB = 2'b11;
                StExecR: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                StExecI: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                end
                StMemAddr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWr: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StWbAlu: begin
                    RegWrite = 1'b1;
                    RegDst   = !OPCODE[3];
                end
                StWbMem: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                StBranch: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b01;
                    PCSource = 1'b1;
                    PCWrite  = ((OPCODE == 4'b0110) && Zero) || ((OPCODE == 4'b0111) && !Zero);
                end
                StHalt:  Halted    = 1'b1;
                StTrap:  IllegalOp = 1'b1;
                default: IllegalOp = 1'b1;
            endcase
        end
    end

    assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with MAX_WAIT=4 and CNT_W=4.
module tb_multicycle_control_fsm;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] OPCODE = 4'b0001;
    logic [1:0] FUNCT = 2'b00;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource;
    logic       RegWrite, RegDst, MemToReg, ALUSrcA, Halted, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] InstrCount;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control_fsm #(
        .MAX_WAIT(4),
        .CNT_W   (4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .OPCODE    (OPCODE),
        .FUNCT     (FUNCT),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCSource  (PCSource),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemToReg  (MemToReg),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .Halted    (Halted),
        .IllegalOp (IllegalOp),
        .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
    endtask

    // One branch instruction from FETCH back to FETCH, MemReady held high.
    task automatic run_branch(input logic [3:0] op, input logic z);
        OPCODE   = op;
        Zero     = z;
        MemReady = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        #1;
        check("rst_memread", MemRead, 0);
        check("rst_pcwrite", PCWrite, 0);
        step();
        step();
        Reset = 1'b0;
        #1;
        check("rst_count", InstrCount, 0);
        check("rst_halted", Halted, 0);
        check("rst_illegal", IllegalOp, 0);

        // ADD
        check("add_f_memread", MemRead, 1);
        check("add_f_irwrite", IRWrite, 1);
        check("add_f_pcwrite", PCWrite, 1);
        check("add_f_srcb", ALUSrcB, 1);
        check("add_f_aluop", ALUOp, 0);
        step();
        check("add_d_srcb", ALUSrcB, 3);
        check("add_d_aluop", ALUOp, 0);
        check("add_d_regwrite", RegWrite, 0);
        step();
        check("add_x_aluop", ALUOp, 2);
        check("add_x_srca", ALUSrcA, 1);
        check("add_x_regwrite", RegWrite, 0);
        step();
        check("add_wb_regwrite", RegWrite, 1);
        check("add_wb_regdst", RegDst, 1);
        check("add_wb_aluop", ALUOp, 0);
        check("add_wb_count", InstrCount, 0);
        step();
        check("add_count", InstrCount, 1);
        check("add_f_regwrite", RegWrite, 0);

        // LW with three wait cycles in MEM_RD
        OPCODE = 4'b0100;
        step();
        step();
        check("lw_ma_srcb", ALUSrcB, 2);
        check("lw_ma_srca", ALUSrcA, 1);
        MemReady = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_rd_memread", MemRead, 1);
            check("lw_rd_iord", IorD, 1);
            step();
        end
        MemReady = 1'b1;
        #1;
        check("lw_rd4_memread", MemRead, 1);
        check("lw_rd4_illegal", IllegalOp, 0);
        step();
        check("lw_wb_regwrite", RegWrite, 1);
        check("lw_wb_memtoreg", MemToReg, 1);
        check("lw_wb_regdst", RegDst, 0);
        step();
        check("lw_count", InstrCount, 2);
        check("lw_back_fetch", IRWrite, 1);

        // BEQ / BNE
        OPCODE = 4'b0110;
        Zero   = 1'b1;
        step();
        step();
        check("beq_z1_pcwrite", PCWrite, 1);
        check("beq_pcsource", PCSource, 1);
        check("beq_aluop", ALUOp, 1);
        Zero = 1'b0;
        #1;
        check("beq_z0_pcwrite", PCWrite, 0);
        step();
        check("beq_count", InstrCount, 3);
        OPCODE = 4'b0111;
        step();
        step();
        check("bne_z0_pcwrite", PCWrite, 1);
        Zero = 1'b1;
        #1;
        check("bne_z1_pcwrite", PCWrite, 0);
        step();
        check("bne_count", InstrCount, 4);

        // I-type
        OPCODE = 4'b1001;
        step();
        step();
        check("addi_x_aluop", ALUOp, 3);
        check("addi_x_srcb", ALUSrcB, 2);
        step();
        check("addi_wb_regdst", RegDst, 0);
        check("addi_wb_regwrite", RegWrite, 1);
        step();
        check("addi_count", InstrCount, 5);

        // SW aborted by reset in MEM_WR
        OPCODE = 4'b0101;
        step();
        step();
        MemReady = 1'b0;
        step();
        check("sw_wr_memwrite", MemWrite, 1);
        check("sw_wr_iord", IorD, 1);
        Reset = 1'b1;
        #1;
        check("sw_rst_memwrite", MemWrite, 0);
        step();
        Reset = 1'b0;
        #1;
        check("sw_rst_fetch", MemRead, 1);
        check("sw_rst_memwrite2", MemWrite, 0);
        check("sw_rst_count", InstrCount, 0);

        // Counter wrap
        for (int i = 0; i < 15; i++) run_branch(4'b0110, 1'b0);
        check("wrap_15", InstrCount, 15);
        run_branch(4'b0110, 1'b0);
        check("wrap_0", InstrCount, 0);

        // FETCH timeout
        MemReady = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("to_fetch_memread", MemRead, 1);
            check("to_fetch_illegal", IllegalOp, 0);
            step();
        end
        check("to_trap_illegal", IllegalOp, 1);
        check("to_trap_memread", MemRead, 0);
        MemReady = 1'b1;
        step();
        step();
        check("to_sticky_illegal", IllegalOp, 1);
        check("to_sticky_memread", MemRead, 0);
        check("to_sticky_pcwrite", PCWrite, 0);
        check("to_count", InstrCount, 0);

        // Illegal opcode
        do_reset();
        check("ill_rst_illegal", IllegalOp, 0);
        OPCODE = 4'b1100;
        step();
        step();
        check("ill_illegal", IllegalOp, 1);

        // Bad FUNCT on opcode 0000
        do_reset();
        OPCODE = 4'b0000;
        FUNCT  = 2'b11;
        step();
        step();
        check("funct_illegal", IllegalOp, 1);
        FUNCT = 2'b00;

        // HALT
        do_reset();
        OPCODE = 4'b1111;
        step();
        step();
        check("halt_halted", Halted, 1);
        check("halt_pcwrite", PCWrite, 0);
        Zero = 1'b1;
        step();
        step();
        check("halt_stay", Halted, 1);
        check("halt_nopc", PCWrite, 0);
        check("halt_nomem", MemRead, 0);
        check("halt_count", InstrCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
